ldl_rr_dispatch: RTL
====================

# ldl_rr_dispatch

Round-robin credit-based dispatcher: accepts one stream of work items, each tagged with a class of service (COS), and steers each item to one of REQ_WIDTH downstream destinations. It is the counterpart of the priority round-robin arbiter, which merges many requesters into one; this block fans one source out to many sinks. Per-destination credit counters provide flow control, and an optional reserve keeps the last credits of each destination for top-COS traffic.

## Interface
- BIN_WIDTH, 3, width of destination index
- COS_WIDTH, 2, width of class of service; 0 lowest, all-ones highest
- REQ_WIDTH, 1 << BIN_WIDTH, number of destinations
- CREDIT_WIDTH, 4, width of each credit counter
- CREDIT_INIT, 8, credits per destination after reset; must be ≤ 2^CREDIT_WIDTH−1 and ≥ 1
- RESERVE, 2, credits per destination reserved for top COS; must be < CREDIT_INIT

- clk  input  1  clock; all state on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  item offered
- in_cos  input  COS_WIDTH  COS of offered item
- in_ready  output  1  item can be accepted this cycle (combinational)
- credit_ret  input  REQ_WIDTH  per-destination credit return pulses, one credit per set bit per cycle
- grant  output  REQ_WIDTH  registered one-hot destination of the dispatched item
- bin  output  BIN_WIDTH  registered binary index of the same destination
- valid  output  1  registered; grant/bin are meaningful for one cycle
- err  output  1  sticky credit-overflow flag

## Operation
- State: credit[i] (CREDIT_WIDTH) for each destination; ptr (BIN_WIDTH), the round-robin start index; output registers; err.
- Eligibility, with the reserve feature: eligible[i] = credit[i] > RESERVE, or (credit[i] > 0 and in_cos is all-ones).
- Eligibility, without the reserve feature: eligible[i] = credit[i] > 0.
- in_ready = OR of eligible[]. It does not depend on in_valid.
- Transfer occurs when in_valid && in_ready.
- Selection: sel is the first eligible index found scanning ptr, ptr+1, … with wrap modulo REQ_WIDTH.
- On transfer:
  - ptr ← (sel+1) mod REQ_WIDTH.
  - credit[sel] decrements.
  - grant ← one-hot(sel), bin ← sel, valid ← 1.
- With no transfer: valid ← 0, grant ← 0, bin holds its last value, ptr holds.
- Credit update per destination per cycle:
  - +1 if credit_ret[i].
  - −1 if dispatched to i.
  - Both in the same cycle: unchanged.
- Overflow: a return that would push credit[i] above CREDIT_INIT saturates at CREDIT_INIT and sets err. err clears only on rst.
- Credit reads for eligibility use the registered value. A credit returned in cycle N is usable in cycle N+1.
- Reset values: credit[i] = CREDIT_INIT, ptr = 0, grant = 0, bin = 0, valid = 0, err = 0.
- Reset asserted mid-operation discards any in-flight grant and restores all credits to CREDIT_INIT. Returns arriving during reset are ignored.

## Timing
- Latency: an item accepted in cycle N produces valid/grant/bin in cycle N+1, high for exactly one cycle.
- Back-to-back acceptance every cycle is supported, limited only by credits.
- in_ready follows in_cos combinationally. A non-top-COS item may see in_ready = 0 while a top-COS item in the same state would see 1.
- Upstream must hold in_valid/in_cos until in_ready; the block does not check this.
- Credit exhaustion: when every destination is at 0 (or at ≤ RESERVE for non-top COS), in_ready = 0 until a return.

## Configuration
- LDL_RR_DISPATCH_RESERVE_EN
  - Defined: the RESERVE threshold applies to non-top-COS items, as above.
  - Undefined: all COS values are treated identically, the RESERVE parameter is ignored, and in_cos is unused.

## Test plan
- Reset, then in_valid = 1 with in_cos = 3 held for 8 cycles, no returns -> bin = 0,1,…,7 on consecutive cycles each with valid = 1; every credit ends at 7.
- Credits exhausted: 64 top-COS transfers, no returns -> in_ready = 0 after the 64th transfer. Then credit_ret = 8'b0001_0000 -> in_ready = 1 next cycle and the next item goes to bin = 4.
- With the reserve feature defined and in_cos = 0: drain until all credits are 2 -> in_ready = 0. Switch to in_cos = 3 in the same cycle -> in_ready = 1 and dispatch proceeds until credits reach 0.
- Simultaneous dispatch to destination 5 and credit_ret[5] -> credit[5] unchanged; ptr advances to 6.
- credit_ret[2] pulsed right after reset (credit already 8) -> credit stays 8 and err = 1, and err holds until rst.
- rst asserted the cycle after an accept -> valid = 0 and grant = 0 immediately. After release the first dispatch goes to bin = 0 with all credits at 8.

Source files
------------

// File: rtl/ldl_rr_dispatch.sv
// Round-robin credit-based dispatcher: fans one COS-tagged stream out to REQ_WIDTH sinks.
// Optional top-COS credit reserve enabled by `define LDL_RR_DISPATCH_RESERVE_EN.
module ldl_rr_dispatch #(
    parameter int BIN_WIDTH    = 3,
    parameter int COS_WIDTH    = 2,
    parameter int REQ_WIDTH    = 1 << BIN_WIDTH,
    parameter int CREDIT_WIDTH = 4,
    parameter int CREDIT_INIT  = 8,
    parameter int RESERVE      = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [COS_WIDTH-1:0] in_cos,
    output logic                 in_ready,
    input  logic [REQ_WIDTH-1:0] credit_ret,
    output logic [REQ_WIDTH-1:0] grant,
    output logic [BIN_WIDTH-1:0] bin,
    output logic                 valid,
    output logic                 err
);

    localparam logic [CREDIT_WIDTH-1:0] INIT_C = CREDIT_WIDTH'(CREDIT_INIT);

    logic [CREDIT_WIDTH-1:0] credit_q [REQ_WIDTH];
    logic [CREDIT_WIDTH-1:0] credit_d [REQ_WIDTH];
    logic [BIN_WIDTH-1:0]    ptr_q, ptr_d;
    logic [REQ_WIDTH-1:0]    grant_q, grant_d;
    logic [BIN_WIDTH-1:0]    bin_q, bin_d;
    logic                    valid_q, valid_d;
    logic                    err_q, err_d;

    logic [REQ_WIDTH-1:0]    eligible;
    logic [BIN_WIDTH-1:0]    sel;
    logic [BIN_WIDTH-1:0]    idx;
    logic                    found;
    logic                    xfer;

`ifdef LDL_RR_DISPATCH_RESERVE_EN
    localparam logic [CREDIT_WIDTH-1:0] RES_C = CREDIT_WIDTH'(RESERVE);

    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < REQ_WIDTH; i++) begin
            eligible[i] = (credit_q[i] > RES_C) ||
                          ((credit_q[i] != '0) && (in_cos == '1));
        end
    end
`else
    localparam int unsigned unused_reserve = RESERVE;
    logic unused_cos;
    assign unused_cos = ^in_cos;

    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < REQ_WIDTH; i++) begin
            eligible[i] = credit_q[i] != '0;
        end
    end
`endif

    assign in_ready = |eligible;
    assign xfer     = in_valid && in_ready;

    // Rotating scan from ptr; index arithmetic wraps since REQ_WIDTH is a power of two.
    always_comb begin
        sel   = ptr_q;
        found = 1'b0;
        idx   = ptr_q;
        for (int unsigned k = 0; k < REQ_WIDTH; k++) begin
            idx = ptr_q + BIN_WIDTH'(k);
            if (!found && eligible[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d   = ptr_q;
        grant_d = '0;
        bin_d   = bin_q;
        valid_d = 1'b0;
        err_d   = err_q;
        if (xfer) begin
            ptr_d      = sel + BIN_WIDTH'(1);
            grant_d[sel] = 1'b1;
            bin_d      = sel;
            valid_d    = 1'b1;
        end
        for (int unsigned i = 0; i < REQ_WIDTH; i++) begin
            credit_d[i] = credit_q[i];
            if (credit_ret[i] && !(xfer && (sel == BIN_WIDTH'(i)))) begin
                if (credit_q[i] >= INIT_C) begin
                    err_d = 1'b1;
                end else begin
                    credit_d[i] = credit_q[i] + CREDIT_WIDTH'(1);
                end
            end else if (!credit_ret[i] && xfer && (sel == BIN_WIDTH'(i))) begin
                credit_d[i] = credit_q[i] - CREDIT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < REQ_WIDTH; i++) begin
                credit_q[i] <= INIT_C;
            end
            ptr_q   <= '0;
            grant_q <= '0;
            bin_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < REQ_WIDTH; i++) begin
                credit_q[i] <= credit_d[i];
            end
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            bin_q   <= bin_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign grant = grant_q;
    assign bin   = bin_q;
    assign valid = valid_q;
    assign err   = err_q;

endmodule
